// File: rtl/move_controller_if.sv
// Click, board-read, move-generator and pick/place signals of the move controller.
// master = controller side, slave = surrounding board/generator/mouse logic.
interface move_controller_if;
    logic        click;
    logic [5:0]  click_pos;
    logic [3:0]  sq_code;
    logic [63:0] possible_moves;
    logic        gen_done;
    logic [5:0]  sq_addr;
    logic        gen_req;
    logic [5:0]  gen_pos;
    logic        pick_piece;
    logic        place_piece;
    logic [5:0]  figure_position;
    logic        sel_valid;
    logic [5:0]  sel_pos;
    logic        turn;
    logic        move_done;
    logic        capture;
    logic [3:0]  captured_code;
    logic        game_over;

    modport master (
        input  click, click_pos, sq_code, possible_moves, gen_done,
        output sq_addr, gen_req, gen_pos, pick_piece, place_piece, figure_position,
               sel_valid, sel_pos, turn, move_done, capture, captured_code, game_over
    );
    modport slave (
        output click, click_pos, sq_code, possible_moves, gen_done,
        input  sq_addr, gen_req, gen_pos, pick_piece, place_piece, figure_position,
               sel_valid, sel_pos, turn, move_done, capture, captured_code, game_over
    );
endinterface

// File: rtl/move_controller.sv
// Turns square clicks into pick/place sequences for the board: turn order, own-piece
// selection, legal destinations from the generator mask, capture and king-capture reporting.
module move_controller #(
    parameter int RD_LAT      = 2,
    parameter int GEN_TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    move_controller_if.master bus
);
    localparam int CMAX = (RD_LAT > GEN_TIMEOUT) ? RD_LAT : GEN_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE, RD_SRC, WAIT_GEN, PICK, SELECTED, RD_DST, PLACE, PLACE_BACK
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [5:0]    src, src_nxt, dst, dst_nxt;
    logic [63:0]   mask, mask_nxt;
    logic          cap_flag, cap_flag_nxt;
    logic [3:0]    cap_code, cap_code_nxt;

    logic [5:0] sq_addr_nxt, gen_pos_nxt, fig_nxt, sel_pos_nxt;
    logic [3:0] captured_code_nxt;
    logic       gen_req_nxt, pick_nxt, place_nxt, move_done_nxt, capture_nxt;
    logic       sel_valid_nxt, turn_nxt, game_over_nxt;
    logic       own;

    assign own = bus.turn ? (bus.sq_code >= 4'd7 && bus.sq_code <= 4'd12)
                          : (bus.sq_code >= 4'd1 && bus.sq_code <= 4'd6);

    always_comb begin
        state_nxt         = state;
        cnt_nxt           = cnt + 1'b1;
        src_nxt           = src;
        dst_nxt           = dst;
        mask_nxt          = mask;
        cap_flag_nxt      = cap_flag;
        cap_code_nxt      = cap_code;
        sq_addr_nxt       = bus.sq_addr;
        gen_pos_nxt       = bus.gen_pos;
        fig_nxt           = bus.figure_position;
        sel_valid_nxt     = bus.sel_valid;
        sel_pos_nxt       = bus.sel_pos;
        turn_nxt          = bus.turn;
        captured_code_nxt = bus.captured_code;
        game_over_nxt     = bus.game_over;
        gen_req_nxt       = 1'b0;
        pick_nxt          = 1'b0;
        place_nxt         = 1'b0;
        move_done_nxt     = 1'b0;
        capture_nxt       = 1'b0;

        case (state)
            IDLE: if (bus.click && !bus.game_over) begin
                src_nxt     = bus.click_pos;
                sq_addr_nxt = bus.click_pos;
                state_nxt   = RD_SRC;
            end
            RD_SRC: if (cnt == CW'(RD_LAT - 1)) begin
                if (own) begin
                    gen_req_nxt = 1'b1;
                    gen_pos_nxt = src;
                    state_nxt   = WAIT_GEN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT_GEN: begin
                // A gen_done arriving on the timeout edge still wins.
                if (bus.gen_done) begin
                    mask_nxt      = bus.possible_moves;
                    pick_nxt      = 1'b1;
                    fig_nxt       = src;
                    sel_valid_nxt = 1'b1;
                    sel_pos_nxt   = src;
                    state_nxt     = PICK;
                end else if (cnt == CW'(GEN_TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                end
            end
            PICK: state_nxt = SELECTED;
            SELECTED: if (bus.click) begin
                if (bus.click_pos == src) begin
                    dst_nxt   = bus.click_pos;
                    state_nxt = PLACE_BACK;
                end else if (mask[6'd63 - bus.click_pos]) begin
                    dst_nxt     = bus.click_pos;
                    sq_addr_nxt = bus.click_pos;
                    state_nxt   = RD_DST;
                end
            end
            RD_DST: if (cnt == CW'(RD_LAT - 1)) begin
                cap_flag_nxt = (bus.sq_code != 4'd0);
                cap_code_nxt = bus.sq_code;
                state_nxt    = PLACE;
            end
            PLACE: begin
                place_nxt     = 1'b1;
                fig_nxt       = dst;
                move_done_nxt = 1'b1;
                if (cap_flag) begin
                    capture_nxt       = 1'b1;
                    captured_code_nxt = cap_code;
                    if (cap_code == 4'd6 || cap_code == 4'd12) game_over_nxt = 1'b1;
                end
                turn_nxt      = ~bus.turn;
                sel_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end
            PLACE_BACK: begin
                place_nxt     = 1'b1;
                fig_nxt       = src;
                sel_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt != state) cnt_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            cnt                 <= '0;
            src                 <= '0;
            dst                 <= '0;
            mask                <= '0;
            cap_flag            <= 1'b0;
            cap_code            <= '0;
            bus.sq_addr         <= '0;
            bus.gen_req         <= 1'b0;
            bus.gen_pos         <= '0;
            bus.pick_piece      <= 1'b0;
            bus.place_piece     <= 1'b0;
            bus.figure_position <= '0;
            bus.sel_valid       <= 1'b0;
            bus.sel_pos         <= '0;
            bus.turn            <= 1'b0;
            bus.move_done       <= 1'b0;
            bus.capture         <= 1'b0;
            bus.captured_code   <= '0;
            bus.game_over       <= 1'b0;
        end else begin
            state               <= state_nxt;
            cnt                 <= cnt_nxt;
            src                 <= src_nxt;
            dst                 <= dst_nxt;
            mask                <= mask_nxt;
            cap_flag            <= cap_flag_nxt;
            cap_code            <= cap_code_nxt;
            bus.sq_addr         <= sq_addr_nxt;
            bus.gen_req         <= gen_req_nxt;
            bus.gen_pos         <= gen_pos_nxt;
            bus.pick_piece      <= pick_nxt;
            bus.place_piece     <= place_nxt;
            bus.figure_position <= fig_nxt;
            bus.sel_valid       <= sel_valid_nxt;
            bus.sel_pos         <= sel_pos_nxt;
            bus.turn            <= turn_nxt;
            bus.move_done       <= move_done_nxt;
            bus.capture         <= capture_nxt;
            bus.captured_code   <= captured_code_nxt;
            bus.game_over       <= game_over_nxt;
        end
    end
endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: board read model with a one-register read path
// (RD_LAT=2 as seen from sq_addr), hand-driven generator replies, pulse monitor.
module tb_move_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    move_controller_if bus ();

    move_controller #(.RD_LAT(2), .GEN_TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] board [64];
    always @(posedge clk) bus.sq_code <= board[bus.sq_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_gen = 0, n_pick = 0, n_place = 0, n_done = 0, n_cap = 0, n_both = 0;
    int gen_cyc, pick_cyc, place_cyc, done_cyc, cap_cyc;
    logic [5:0] gen_pos_l, pick_pos_l, place_pos_l;
    always @(posedge clk) begin
        #1;
        if (bus.gen_req)     begin n_gen++;   gen_cyc = cyc;   gen_pos_l = bus.gen_pos; end
        if (bus.pick_piece)  begin n_pick++;  pick_cyc = cyc;  pick_pos_l = bus.figure_position; end
        if (bus.place_piece) begin n_place++; place_cyc = cyc; place_pos_l = bus.figure_position; end
        if (bus.move_done)   begin n_done++;  done_cyc = cyc; end
        if (bus.capture)     begin n_cap++;   cap_cyc = cyc; end
        if (bus.pick_piece && bus.place_piece) n_both++;
    end

    int n_chk = 0, n_err = 0;
    int click_cyc, gd_cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int get_cnt(input int w);
        case (w)
            0: return n_gen;
            1: return n_pick;
            default: return n_place;
        endcase
    endfunction

    task automatic wait_cnt(input string tag, input int w, input int target);
        int i = 0;
        while (get_cnt(w) < target && i < 40) begin
            @(negedge clk);
            i++;
        end
        check(tag, 64'(get_cnt(w) >= target), 64'd1);
    endtask

    task automatic do_click(input logic [5:0] p);
        @(negedge clk);
        bus.click = 1'b1;
        bus.click_pos = p;
        click_cyc = cyc;
        @(negedge clk);
        bus.click = 1'b0;
    endtask

    task automatic gen_reply(input logic [63:0] m);
        bus.possible_moves = m;
        bus.gen_done = 1'b1;
        gd_cyc = cyc;
        @(negedge clk);
        bus.gen_done = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [63:0] bitm(input logic [5:0] p);
        return 64'd1 << (63 - int'(p));
    endfunction

    function automatic logic [63:0] out_vec();
        return {bus.sq_addr, bus.gen_pos, bus.figure_position, bus.sel_pos, bus.captured_code,
                bus.gen_req, bus.pick_piece, bus.place_piece, bus.sel_valid, bus.turn,
                bus.move_done, bus.capture, bus.game_over};
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) board[i] = 4'd0;
        board[6'o64] = 4'd1;   // white pawn
        board[6'o44] = 4'd12;  // black king
        board[6'o14] = 4'd7;   // black pawn
        board[6'o24] = 4'd2;   // white knight
        board[6'o33] = 4'd13;  // invalid code
        bus.click = 1'b0;
        bus.click_pos = '0;
        bus.gen_done = 1'b0;
        bus.possible_moves = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // white pawn o64 -> o54
        do_click(6'o64);
        wait_cnt("gen_req_1", 0, 1);
        check("gen_pos_1", gen_pos_l, 6'o64);
        check("gen_lat", gen_cyc - click_cyc, 3);
        gen_reply(bitm(6'o54));
        wait_cnt("pick_1", 1, 1);
        check("pick_pos_1", pick_pos_l, 6'o64);
        check("pick_lat", pick_cyc - gd_cyc, 1);
        check("sel_1", {bus.sel_valid, bus.sel_pos}, {1'b1, 6'o64});
        do_click(6'o54);
        wait_cnt("place_1", 2, 1);
        check("place_pos_1", place_pos_l, 6'o54);
        check("place_lat", place_cyc - click_cyc, 4);
        check("done_1", {n_done, done_cyc}, {32'd1, 32'(place_cyc)});
        check("turn_1", bus.turn, 1'b1);
        check("nocap_1", n_cap, 0);
        check("sel_clr_1", bus.sel_valid, 1'b0);
        board[6'o64] = 4'd0;
        board[6'o54] = 4'd1;

        // black to move: white piece, empty square and code D are all rejected
        do_click(6'o54);
        repeat (8) @(negedge clk);
        do_click(6'o30);
        repeat (8) @(negedge clk);
        do_click(6'o33);
        repeat (8) @(negedge clk);
        check("reject_gen", n_gen, 1);
        check("reject_pick", n_pick, 1);

        // black o14: illegal destination ignored, then put back
        do_click(6'o14);
        wait_cnt("gen_req_2", 0, 2);
        gen_reply(bitm(6'o24));
        wait_cnt("pick_2", 1, 2);
        do_click(6'o34);
        repeat (8) @(negedge clk);
        check("illegal_noplace", n_place, 1);
        check("illegal_held", bus.sel_valid, 1'b1);
        do_click(6'o14);
        wait_cnt("place_back", 2, 2);
        check("back_pos", place_pos_l, 6'o14);
        check("back_nodone", n_done, 1);
        check("back_turn", {bus.turn, bus.sel_valid}, 2'b10);

        // black pawn takes white knight on o24
        do_click(6'o14);
        wait_cnt("gen_req_3", 0, 3);
        gen_reply(bitm(6'o24));
        wait_cnt("pick_3", 1, 3);
        do_click(6'o24);
        wait_cnt("place_3", 2, 3);
        check("cap_n_1", n_cap, 1);
        check("cap_sync_1", cap_cyc, place_cyc);
        check("cap_code_1", bus.captured_code, 4'd2);
        check("cap_nogo", {bus.game_over, bus.turn}, 2'b00);
        board[6'o14] = 4'd0;
        board[6'o24] = 4'd7;

        // white pawn takes black king
        do_click(6'o54);
        wait_cnt("gen_req_4", 0, 4);
        gen_reply(bitm(6'o44));
        wait_cnt("pick_4", 1, 4);
        do_click(6'o44);
        wait_cnt("place_4", 2, 4);
        check("king_cap", {n_cap, n_done}, {32'd2, 32'd3});
        check("king_code", bus.captured_code, 4'hC);
        check("game_over", {bus.game_over, bus.turn}, 2'b11);
        do_click(6'o24);
        repeat (8) @(negedge clk);
        check("over_ignored", n_gen, 4);

        pulse_reset();
        check("reset_after_game", out_vec(), 64'd0);
        board[6'o64] = 4'd1;

        // generator timeout: gen_done one cycle too late, click during WAIT_GEN ignored
        do_click(6'o64);
        wait_cnt("gen_req_5", 0, 5);
        do_click(6'o54);
        while (cyc < gen_cyc + 255) @(negedge clk);
        gen_reply(bitm(6'o54));
        repeat (4) @(negedge clk);
        check("timeout_nopick", n_pick, 4);
        check("timeout_gen", n_gen, 5);
        check("timeout_sel", bus.sel_valid, 1'b0);

        // gen_done in the last waiting cycle is accepted
        do_click(6'o64);
        wait_cnt("gen_req_6", 0, 6);
        while (cyc < gen_cyc + 254) @(negedge clk);
        gen_reply(bitm(6'o54));
        wait_cnt("late_pick", 1, 5);
        check("late_sel", {bus.sel_valid, bus.sel_pos}, {1'b1, 6'o64});

        // reset while a piece is held, then a fresh selection
        pulse_reset();
        check("reset_selected", out_vec(), 64'd0);
        do_click(6'o64);
        wait_cnt("gen_req_7", 0, 7);
        check("gen_pos_7", gen_pos_l, 6'o64);
        gen_reply(bitm(6'o54));
        wait_cnt("pick_6", 1, 6);
        do_click(6'o64);
        wait_cnt("place_5", 2, 5);
        check("final_place", {place_pos_l, bus.turn}, {6'o64, 1'b0});
        check("pick_place_overlap", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
